// File: rtl/tim_pkg.sv
// rtl/tim_pkg.sv - shared mode encoding for the multi-channel interval timer
package tim_pkg;

  typedef enum logic [1:0] {
    TIM_ONESHOT  = 2'b00,
    TIM_RETRIG   = 2'b01,
    TIM_PERIODIC = 2'b10,
    TIM_RESERVED = 2'b11
  } tim_mode_e;

endpackage

// File: rtl/tim_multi_if.sv
// rtl/tim_multi_if.sv - trigger/control/status bundle for tim_multi
interface tim_multi_if #(
  parameter int N  = 4,
  parameter int CH = 4
);

  logic [CH-1:0]   trig;
  logic [CH-1:0]   edge_sel;
  logic [2*CH-1:0] mode;
  logic [N*CH-1:0] load;
  logic [CH-1:0]   abort;
  logic [CH-1:0]   pulse;
  logic [CH-1:0]   busy;
  logic [CH-1:0]   missed;
  logic            irq;

  modport master (
    output trig, edge_sel, mode, load, abort,
    input  pulse, busy, missed, irq
  );

  modport slave (
    input  trig, edge_sel, mode, load, abort,
    output pulse, busy, missed, irq
  );

endinterface

// File: rtl/tim_ch.sv
// rtl/tim_ch.sv - one timer channel: edge detect, counter, snapshots and flags
module tim_ch
  import tim_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         trig,
  input  logic         edge_sel,
  input  logic [1:0]   mode,
  input  logic [N-1:0] load,
  input  logic         abort,
  output logic         pulse,
  output logic         busy,
  output logic         missed
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic          trig_r;
  logic [N-1:0]  cnt;
  logic [N-1:0]  period_q;
  tim_mode_e     mode_q;

  logic evt;
  logic load_ok;
  logic expire;

  // Trigger event, valid load and terminal count are all decoded from current state.
  always_comb begin
    evt     = edge_sel ? (trig & ~trig_r) : (~trig & trig_r);
    load_ok = (load != '0);
    expire  = (cnt == (period_q - ONE));
  end

  // Channel state: abort dominates, then idle start, then per-mode counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_r   <= 1'b0;
      cnt      <= '0;
      period_q <= '0;
      mode_q   <= TIM_ONESHOT;
      pulse    <= 1'b0;
      busy     <= 1'b0;
      missed   <= 1'b0;
    end else begin
      trig_r <= trig;
      if (abort) begin
        busy   <= 1'b0;
        cnt    <= '0;
        missed <= 1'b0;
        pulse  <= 1'b0;
      end else if (!busy) begin
        pulse <= 1'b0;
        if (evt && load_ok) begin
          busy     <= 1'b1;
          cnt      <= '0;
          period_q <= load;
          mode_q   <= tim_mode_e'(mode);
        end
      end else begin
        case (mode_q)
          TIM_RETRIG: begin
            // A restart beats a coincident expiry, so no pulse in that cycle.
            if (evt && load_ok) begin
              cnt      <= '0;
              period_q <= load;
              pulse    <= 1'b0;
            end else if (expire) begin
              pulse <= 1'b1;
              busy  <= 1'b0;
              cnt   <= '0;
            end else begin
              pulse <= 1'b0;
              cnt   <= cnt + ONE;
            end
          end
          TIM_PERIODIC: begin
            if (evt) missed <= 1'b1;
            if (expire) begin
              pulse <= 1'b1;
              cnt   <= '0;
            end else begin
              pulse <= 1'b0;
              cnt   <= cnt + ONE;
            end
          end
          default: begin
            // One-shot (and the reserved code): expiry wins over a coincident event.
            if (evt) missed <= 1'b1;
            if (expire) begin
              pulse <= 1'b1;
              busy  <= 1'b0;
              cnt   <= '0;
            end else begin
              pulse <= 1'b0;
              cnt   <= cnt + ONE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/tim_multi.sv
// rtl/tim_multi.sv - CH independent interval timer channels with aggregated irq
module tim_multi
  import tim_pkg::*;
#(
  parameter int N  = 4,
  parameter int CH = 4
) (
  input logic         clk,
  input logic         rst,
  tim_multi_if.slave  bus
);

  logic [CH-1:0] pulse_v;
  logic [CH-1:0] busy_v;
  logic [CH-1:0] missed_v;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    tim_ch #(.N(N)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .trig     (bus.trig[c]),
      .edge_sel (bus.edge_sel[c]),
      .mode     (bus.mode[2*c +: 2]),
      .load     (bus.load[N*c +: N]),
      .abort    (bus.abort[c]),
      .pulse    (pulse_v[c]),
      .busy     (busy_v[c]),
      .missed   (missed_v[c])
    );
  end

  // irq is a plain OR of the registered pulses, adding no latency.
  always_comb begin
    bus.pulse  = pulse_v;
    bus.busy   = busy_v;
    bus.missed = missed_v;
    bus.irq    = |pulse_v;
  end

endmodule
